// File: rtl/neurotransmitter_pool.sv
// rtl/neurotransmitter_pool.sv - saturating transmitter level with step, hold and strobe logic
// Optional homeostatic decay toward BASELINE is built when NT_HOMEOSTASIS_EN is defined.
module neurotransmitter_pool #(
  parameter int N            = 7,
  parameter int DEFAULT_VAL  = 96,
  parameter int SET_VAL      = 64,
  parameter int BASELINE     = 64,
  parameter int SLOW_STEP    = 1,
  parameter int FAST_STEP    = 3,
  parameter int DECAY_PERIOD = 16,
  parameter int LEVEL_BITS   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc,
  input  logic                  dec,
  input  logic                  fast,
  input  logic                  setval,
  input  logic                  hold,
  output logic [N-1:0]          value,
  output logic [LEVEL_BITS-1:0] level,
  output logic                  at_max,
  output logic                  at_min,
  output logic                  changed
);

  localparam logic [N-1:0] MAXV    = '1;
  localparam logic [N-1:0] DEF_N   = N'(DEFAULT_VAL);
  localparam logic [N-1:0] SET_N   = N'(SET_VAL);

  logic [N-1:0] r_value;
  logic         r_changed;
  logic [N:0]   w_step;
  logic [N:0]   w_sum;
  logic [N:0]   w_diff;
  logic [N-1:0] w_next;
  logic         w_move;

  assign w_step = fast ? (N+1)'(FAST_STEP) : (N+1)'(SLOW_STEP);
  assign w_sum  = {1'b0, r_value} + w_step;
  assign w_diff = {1'b0, r_value} - w_step;
  assign w_move = !setval && !hold && (inc ^ dec);

`ifdef NT_HOMEOSTASIS_EN
  localparam int           CW     = $clog2(DECAY_PERIOD);
  localparam logic [N-1:0] BASE_N = N'(BASELINE);

  logic [CW-1:0] r_cnt;
  logic          w_idle;
  logic          w_tick;
  logic [N-1:0]  w_toward;

  assign w_idle = !setval && !hold && !(inc ^ dec);
  assign w_tick = w_idle && (r_cnt == CW'(DECAY_PERIOD - 1));

  always_comb begin
    w_toward = r_value;
    if (r_value > BASE_N)
      w_toward = r_value - N'(1);
    else if (r_value < BASE_N)
      w_toward = r_value + N'(1);
  end

  // Any setval or effective step restarts the idle count, even when saturated.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (setval || w_move)
      r_cnt <= '0;
    else if (w_idle)
      r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
  end
`endif

  always_comb begin
    w_next = r_value;
    if (setval)
      w_next = SET_N;
    else if (hold)
      w_next = r_value;
    else if (w_move) begin
      // Bit N of the widened result flags overflow (inc) or borrow (dec).
      if (inc)
        w_next = w_sum[N] ? MAXV : w_sum[N-1:0];
      else
        w_next = w_diff[N] ? '0 : w_diff[N-1:0];
    end
`ifdef NT_HOMEOSTASIS_EN
    else if (w_tick)
      w_next = w_toward;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_value   <= DEF_N;
      r_changed <= 1'b0;
    end else begin
      r_value   <= w_next;
      r_changed <= (w_next != r_value);
    end
  end

  assign value   = r_value;
  assign changed = r_changed;
  assign level   = r_value[N-1 -: LEVEL_BITS];
  assign at_max  = (r_value == MAXV);
  assign at_min  = (r_value == '0);

endmodule

// File: tb/tb_neurotransmitter_pool.sv
// tb/tb_neurotransmitter_pool.sv - scoreboard bench for neurotransmitter_pool
// Reference model follows NT_HOMEOSTASIS_EN the same way the design does.
module tb_neurotransmitter_pool;

  logic       clk = 1'b0;
  logic       rst_n, inc, dec, fast, setval, hold;
  logic [6:0] value;
  logic [1:0] level;
  logic       at_max, at_min, changed;

  int n_chk = 0;
  int n_err = 0;

  int m_val = 96;
  int m_cnt = 0;

  typedef struct {
    int val;
    int chg;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  neurotransmitter_pool dut (
    .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec), .fast(fast),
    .setval(setval), .hold(hold), .value(value), .level(level),
    .at_max(at_max), .at_min(at_min), .changed(changed)
  );

  task automatic check_eq(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq("scoreboard_empty", 0, 1);
      return;
    end
    e = sb_q.pop_front();
    check_eq("value", int'(value), e.val);
    check_eq("level", int'(level), e.val / 32);
    check_eq("at_max", int'(at_max), (e.val == 127) ? 1 : 0);
    check_eq("at_min", int'(at_min), (e.val == 0) ? 1 : 0);
    check_eq("changed", int'(changed), e.chg);
  endtask

  task automatic do_reset(input int cycles);
    exp_t e;
    rst_n = 1'b0; inc = 1'b0; dec = 1'b0; fast = 1'b0; setval = 1'b0; hold = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      m_val = 96; m_cnt = 0;
      e.val = 96; e.chg = 0;
      sb_q.push_back(e);
      @(posedge clk); #1;
      compare_out();
    end
    rst_n = 1'b1;
  endtask

  task automatic step(input logic a_inc, input logic a_dec, input logic a_fast,
                      input logic a_set, input logic a_hold);
    exp_t e;
    int   nv;
    int   stp;
    inc = a_inc; dec = a_dec; fast = a_fast; setval = a_set; hold = a_hold;
    stp = a_fast ? 3 : 1;
    nv  = m_val;
    if (a_set) begin
      nv = 64; m_cnt = 0;
    end else if (a_hold) begin
      nv = m_val;
    end else if (a_inc && !a_dec) begin
      nv = (m_val + stp > 127) ? 127 : m_val + stp; m_cnt = 0;
    end else if (a_dec && !a_inc) begin
      nv = (m_val - stp < 0) ? 0 : m_val - stp; m_cnt = 0;
    end else begin
`ifdef NT_HOMEOSTASIS_EN
      if (m_cnt == 15) begin
        if (m_val > 64) nv = m_val - 1;
        else if (m_val < 64) nv = m_val + 1;
        m_cnt = 0;
      end else begin
        m_cnt = m_cnt + 1;
      end
`endif
    end
    e.val = nv;
    e.chg = (nv != m_val) ? 1 : 0;
    m_val = nv;
    sb_q.push_back(e);
    @(posedge clk); #1;
    compare_out();
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; inc = 1'b0; dec = 1'b0; fast = 1'b0; setval = 1'b0; hold = 1'b0;
    do_reset(2);

    // fast saturation: 96 + 10*3 = 126, then 127, then stuck
    for (int i = 0; i < 10; i++) step(1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);

    // priority and cancel
    step(1, 0, 0, 1, 1);
    step(1, 1, 0, 0, 0);

    // decay timing and restart by an effective decrease
    do_reset(2);
    idle(20);
    idle(10);
    step(0, 1, 0, 0, 0);
    idle(20);

    // hold freezes level and counter, then reset mid-count
    do_reset(1);
    for (int i = 0; i < 40; i++) step(0, 0, 0, 0, 1);
    idle(8);
    do_reset(1);
    idle(20);

    // long idle stretch
    do_reset(1);
    idle(100);

    // floor saturation
    for (int i = 0; i < 50; i++) step(0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0);

    // random mix
    for (int i = 0; i < 400; i++) begin
      logic [4:0] r;
      r = 5'($urandom_range(0, 31));
      if (r[4] && r[3]) step(0, 0, 0, 0, 0);
      else step(r[0], r[1], r[2], (r[4:1] == 4'b0111), (r[4:2] == 3'b101));
    end

    check_eq("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/neurotransmitter_pool.md
# neurotransmitter_pool

Parametrised, saturating neurotransmitter resource and the next generation of the per-transmitter resource used by the serotonin, dopamine and cortisol systems. It holds one N-bit level driven by combinational regulator requests (inc/dec/fast/setval). Beyond the current resource, it adds configurable step sizes, a freeze input, saturation flags, a change strobe, a configurable quantised output width, and optional homeostatic decay toward a baseline. Each transmitter system instantiates one pool between its regulator and its downscaled level output.

## Interface
- N, 7: width of the level register.
- DEFAULT_VAL, 96: value loaded on reset.
- SET_VAL, 64: value loaded on setval.
- BASELINE, 64: homeostatic target for decay.
- SLOW_STEP, 1: step size when fast=0.
- FAST_STEP, 3: step size when fast=1.
- DECAY_PERIOD, 16: idle cycles per decay step; must be >= 2.
- LEVEL_BITS, 2: width of the quantised output; must be 1..N.

- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- inc  input  1  increase request.
- dec  input  1  decrease request.
- fast  input  1  selects FAST_STEP instead of SLOW_STEP.
- setval  input  1  load SET_VAL.
- hold  input  1  freeze the level and the decay counter.
- value  output  N  current level (registered).
- level  output  LEVEL_BITS  value[N-1:N-LEVEL_BITS].
- at_max  output  1  value == 2^N-1.
- at_min  output  1  value == 0.
- changed  output  1  one-cycle strobe: value differs from its previous-cycle value.

## Operation
- Request priority, evaluated each cycle: setval > hold > (inc XOR dec) > idle.
- setval: value <= SET_VAL; decay counter <= 0.
- hold (without setval): value and counter unchanged.
- Effective increase (inc=1, dec=0): value <= min(value+step, 2^N-1); counter <= 0.
- Effective decrease (dec=1, inc=0): value <= max(value-step, 0); counter <= 0.
- step = fast ? FAST_STEP : SLOW_STEP.
- Compute sums and differences in N+1 bits; saturate, never wrap.
- inc=dec=1 cancels and counts as an idle cycle.
- Idle cycle (with decay compiled in):
  - If counter == DECAY_PERIOD-1: value moves 1 toward BASELINE (unchanged if equal) and counter <= 0.
  - Otherwise: counter <= counter+1.
- Counter width is $clog2(DECAY_PERIOD).
- at_max, at_min and level are decoded combinationally from the value register.
- changed is a register: set to 1 on the cycle after any edge where value changed, 0 otherwise.

## Timing
- Reset values: value=DEFAULT_VAL, counter=0, changed=0. level, at_max and at_min follow from DEFAULT_VAL.
- Reset is evaluated before all requests. Asserting rst_n=0 mid-decay discards the accumulated count.
- Latency: a request sampled at edge k is visible on value after edge k. changed is high during cycle k+1 only.
- Decay: with the counter at 0 and continuous idle, the first decay step appears after the DECAY_PERIOD-th idle edge.
- A setval that loads a value equal to the current value does not raise changed.
- A saturated request with no actual change (e.g. inc at max) does not raise changed, but still clears the counter.

## Configuration
- NT_HOMEOSTASIS_EN defined: idle-cycle decay toward BASELINE as described above.
- NT_HOMEOSTASIS_EN undefined: no decay counter is built. Idle cycles hold value; DECAY_PERIOD and BASELINE are ignored. All other behaviour is identical.

## Test plan
All scenarios use default parameters.
- Reset: hold rst_n=0 for 2 cycles -> value=96, level=3, at_max=0, at_min=0, changed=0.
- Fast saturation: from value=126, inc=1, fast=1 -> value=127, at_max=1, changed=1 for one cycle. A further inc leaves value=127 and changed=0.
- Priority and cancel:
  - setval=1, inc=1, hold=1 in the same cycle -> value=64.
  - Next, inc=dec=1 -> value=64, changed=0.
- Decay (NT_HOMEOSTASIS_EN):
  - From 96, idle for 15 cycles -> value stays 96.
  - 16th idle edge -> value=95, changed pulses.
  - A dec at idle cycle 10 restarts the count.
- Hold and reset mid-operation:
  - hold=1 for 40 cycles at value=96 -> no change.
  - Release, 8 idle cycles, then rst_n=0 -> value=96, counter=0. The next decay step arrives 16 idle cycles after reset release.
- Decay compiled out: 100 idle cycles from 96 -> value stays 96, changed never asserted.
